// File: rtl/bytebasher_pkg.sv
// Shared definitions for the FPGA<->Arduino GPIO link: event codes, frame sync
// pattern and the serial transmitter state encoding.
package bytebasher_pkg;

   localparam logic [1:0] EVT_TARGET = 2'b00;
   localparam logic [1:0] EVT_HIT    = 2'b01;
   localparam logic [1:0] EVT_MISS   = 2'b10;
   localparam logic [1:0] EVT_LOBBY  = 2'b11;

   localparam logic [2:0] FRAME_SYNC = 3'b101;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   typedef struct packed {
      logic [1:0] evtType;
      logic [2:0] evtBox;
   } evt_t;

   // The sync pattern in the top bits lets the Arduino reject line noise.
   function automatic logic [7:0] frameByte(input evt_t e);
      return {FRAME_SYNC, e.evtType, e.evtBox};
   endfunction

endpackage

// File: rtl/gpio_event_tx_if.sv
// Event handshake from the game FSM plus the serial/status outputs of gpio_event_tx.
interface gpio_event_tx_if;

   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_type;
   logic [2:0] evt_box;
   logic       tx_line;
   logic       busy;
   logic [7:0] frames_sent;

   modport master (
      output evt_valid, evt_type, evt_box,
      input  evt_ready, tx_line, busy, frames_sent
   );

   modport slave (
      input  evt_valid, evt_type, evt_box,
      output evt_ready, tx_line, busy, frames_sent
   );

endinterface

// File: rtl/gpio_event_tx_sync_fifo.sv
// Small synchronous FIFO holding queued game events until the serialiser takes them.
module sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                     CLOCK_50,
   input  logic                     resetn,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rdPtr_q];

   always_ff @(posedge CLOCK_50) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/gpio_event_tx.sv
// Sends queued game events to the Arduino as 8N1 UART frames on a single GPIO pin.
module gpio_event_tx
   import bytebasher_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         CLOCK_50,
   input  logic         resetn,
   gpio_event_tx_if.slave evt
);

   localparam int BIT_TICKS = CLK_HZ / BAUD;
   localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam int CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] tickCnt_q, tickCnt_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    framesSent_q, framesSent_d;
   logic          txLine_q, txLine_d;

   evt_t          fifoIn, fifoOut;
   logic          fifoFull, fifoEmpty, push, pop, lastTick;
   logic [CW-1:0] fifoCount;

   assign fifoIn          = '{evtType: evt.evt_type, evtBox: evt.evt_box};
   assign evt.evt_ready   = resetn && (fifoCount < CW'(FIFO_DEPTH));
   assign push            = evt.evt_valid && evt.evt_ready;
   assign lastTick        = (tickCnt_q == TICK_LAST);
   assign evt.tx_line     = txLine_q;
   assign evt.busy        = (state_q != TX_IDLE) || !fifoEmpty;
   assign evt.frames_sent = framesSent_q;

   sync_fifo #(.WIDTH($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .push_i   (push),
      .pop_i    (pop),
      .data_i   (fifoIn),
      .data_o   (fifoOut),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty),
      .count_o  (fifoCount)
   );

   // STOP reloads straight into START when more events wait, so frames go out back-to-back.
   always_comb begin
      state_d      = state_q;
      tickCnt_d    = tickCnt_q + 1'b1;
      bitIdx_d     = bitIdx_q;
      shift_d      = shift_q;
      framesSent_d = framesSent_q;
      pop          = 1'b0;
      case (state_q)
         TX_IDLE: begin
            tickCnt_d = '0;
            if (!fifoEmpty) begin
               pop     = 1'b1;
               shift_d = frameByte(fifoOut);
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (lastTick) begin
               tickCnt_d = '0;
               bitIdx_d  = '0;
               state_d   = TX_DATA;
            end
         end
         TX_DATA: begin
            if (lastTick) begin
               tickCnt_d = '0;
               shift_d   = shift_q >> 1;
               bitIdx_d  = bitIdx_q + 1'b1;
               if (bitIdx_q == 3'd7) state_d = TX_STOP;
            end
         end
         default: begin
            if (lastTick) begin
               tickCnt_d    = '0;
               framesSent_d = framesSent_q + 1'b1;
               if (!fifoEmpty) begin
                  pop     = 1'b1;
                  shift_d = frameByte(fifoOut);
                  state_d = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
      endcase
   end

   always_comb begin
      case (state_q)
         TX_START: txLine_d = 1'b0;
         TX_DATA:  txLine_d = shift_q[0];
         default:  txLine_d = 1'b1;
      endcase
   end

   // The line is registered, so it trails the state by one cycle; every bit still lasts BIT_TICKS.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q      <= TX_IDLE;
         tickCnt_q    <= '0;
         bitIdx_q     <= '0;
         shift_q      <= '0;
         framesSent_q <= '0;
         txLine_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         tickCnt_q    <= tickCnt_d;
         bitIdx_q     <= bitIdx_d;
         shift_q      <= shift_d;
         framesSent_q <= framesSent_d;
         txLine_q     <= txLine_d;
      end
   end

   logic unusedFull;
   assign unusedFull = fifoFull;

endmodule

// File: tb/tb_gpio_event_tx.sv
// Self-checking bench for gpio_event_tx: a timeline model of accepted frames predicts the line.
module tb_gpio_event_tx;

   localparam int CLK_HZ = 100;
   localparam int BAUD   = 10;
   localparam int BT     = CLK_HZ / BAUD;
   localparam int FRAME  = 10 * BT;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [7:0] b;
      int         k;
      int         s;
   } frame_t;

   logic   CLOCK_50 = 1'b0;
   logic   resetn   = 1'b0;
   int     cyc      = 0;
   int     lastStart = -100000;
   int     errCnt   = 0;
   int     chkCnt   = 0;
   logic   checkOn  = 1'b0;
   logic   lastAccepted = 1'b0;
   logic [7:0] mSent = 8'd0;
   frame_t frames[$];

   gpio_event_tx_if evtIf ();

   gpio_event_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .evt      (evtIf)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // A frame accepted on edge k starts at s = max(k+2, previous start + FRAME) and is popped on s-1.
   function automatic int countAt(int t);
      int n = 0;
      foreach (frames[i]) if (frames[i].k <= t && t < frames[i].s - 1) n++;
      return n;
   endfunction

   function automatic logic busyAt(int t);
      foreach (frames[i]) if (frames[i].k <= t && t < frames[i].s + FRAME - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic txAt(int t);
      int idx;
      foreach (frames[i]) begin
         if (frames[i].s <= t && t < frames[i].s + FRAME) begin
            idx = (t - frames[i].s) / BT;
            if (idx == 0) return 1'b0;
            if (idx == 9) return 1'b1;
            return frames[i].b[idx-1];
         end
      end
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] ty, input logic [2:0] bx);
      evtIf.evt_valid = v;
      evtIf.evt_type  = ty;
      evtIf.evt_box   = bx;
   endtask

   task automatic modelUpdate();
      logic   rdy;
      frame_t f;
      rdy = resetn && (countAt(cyc) < DEPTH);
      cyc++;
      lastAccepted = 1'b0;
      if (!resetn) begin
         frames.delete();
         mSent     = 8'd0;
         lastStart = -100000;
      end else begin
         foreach (frames[i]) if (frames[i].s + FRAME - 1 == cyc) mSent++;
         if (evtIf.evt_valid && rdy) begin
            f.b = {3'b101, evtIf.evt_type, evtIf.evt_box};
            f.k = cyc;
            f.s = (cyc + 2 > lastStart + FRAME) ? cyc + 2 : lastStart + FRAME;
            lastStart = f.s;
            frames.push_back(f);
            lastAccepted = 1'b1;
         end
         while (frames.size() > 0 && frames[0].s + FRAME <= cyc) void'(frames.pop_front());
      end
   endtask

   task automatic stepCycle();
      @(posedge CLOCK_50);
      #1;
      modelUpdate();
   endtask

   task automatic sendEvent(input logic [1:0] ty, input logic [2:0] bx, output int acc, output int waited);
      applyStimulus(1'b1, ty, bx);
      acc = -1;
      waited = 0;
      for (int n = 0; n < 500; n++) begin
         stepCycle();
         if (lastAccepted) begin
            acc = cyc;
            break;
         end
         if (evtIf.evt_ready === 1'b0) waited++;
      end
      checkOutput("accept_wait", 32'(lastAccepted), 32'd1);
      applyStimulus(1'b0, ty, bx);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      do begin
         stepCycle();
         n++;
      end while (evtIf.busy !== 1'b0 && n < budget);
      checkOutput("idle_wait", 32'(evtIf.busy), 32'd0);
   endtask

   task automatic runRandom(input int ncyc);
      for (int n = 0; n < ncyc; n++) begin
         stepCycle();
         if (!(evtIf.evt_valid && !lastAccepted)) begin
            if ($urandom_range(99) < 30)
               applyStimulus(1'b1, 2'($urandom_range(3)), 3'($urandom_range(7)));
            else
               applyStimulus(1'b0, evtIf.evt_type, evtIf.evt_box);
         end
      end
      applyStimulus(1'b0, 2'b00, 3'd0);
   endtask

   // Every cycle after the first reset edge, all outputs are compared with the timeline model.
   always @(negedge CLOCK_50) begin
      if (checkOn) begin
         checkOutput("tx_line",     32'(evtIf.tx_line),     32'(txAt(cyc)));
         checkOutput("busy",        32'(evtIf.busy),        32'(busyAt(cyc)));
         checkOutput("frames_sent", 32'(evtIf.frames_sent), 32'(mSent));
         checkOutput("evt_ready",   32'(evtIf.evt_ready),   32'(resetn && (countAt(cyc) < DEPTH)));
      end
   end

   initial begin
      logic [9:0] litBits;
      int acc [6];
      int waited;
      int base;
      logic lowSeen;

      applyStimulus(1'b0, 2'b00, 3'd0);
      resetn = 1'b0;
      stepCycle();
      checkOn = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("rst_tx",    32'(evtIf.tx_line),     32'd1);
      checkOutput("rst_busy",  32'(evtIf.busy),        32'd0);
      checkOutput("rst_sent",  32'(evtIf.frames_sent), 32'd0);
      checkOutput("rst_ready", 32'(evtIf.evt_ready),   32'd0);
      resetn = 1'b1;
      #1;
      checkOutput("release_ready", 32'(evtIf.evt_ready), 32'd1);

      $display("[TB] single HIT event to box 3");
      litBits = 10'b1101010110;
      sendEvent(2'b01, 3'd3, acc[0], waited);
      checkOutput("model_byte", 32'(frames[0].b), 32'h0000_00AB);
      stepCycle();
      for (int i = 0; i < FRAME; i++) begin
         stepCycle();
         checkOutput("frame_AB_bit", 32'(evtIf.tx_line), 32'(litBits[i / BT]));
      end
      checkOutput("single_sent", 32'(evtIf.frames_sent), 32'd1);
      checkOutput("single_busy", 32'(evtIf.busy),        32'd0);

      $display("[TB] six events back-to-back");
      for (int j = 0; j < 6; j++) sendEvent(2'($urandom_range(3)), 3'($urandom_range(7)), acc[j], waited);
      checkOutput("five_consecutive", 32'(acc[4] - acc[0]), 32'd4);
      checkOutput("sixth_stall",      32'(acc[5] - acc[0]), 32'd102);
      waitIdle(1000);
      checkOutput("six_total_cycles", 32'(cyc - acc[0]), 32'd601);
      checkOutput("six_sent",         32'(evtIf.frames_sent), 32'd7);

      $display("[TB] valid held while stalled");
      for (int j = 0; j < 5; j++) sendEvent(EVT(j), 3'(j), acc[j], waited);
      sendEvent(2'b11, 3'd6, acc[5], waited);
      checkOutput("held_stall_ge_50", 32'(waited >= 50), 32'd1);
      checkOutput("held_accept_at",   32'(acc[5] - acc[0]), 32'd102);
      waitIdle(1000);
      checkOutput("held_sent", 32'(evtIf.frames_sent), 32'd13);

      $display("[TB] reset during data bit 3");
      for (int j = 0; j < 3; j++) sendEvent(2'b10, 3'(j + 1), acc[j], waited);
      base = acc[0] + 2 + 4 * BT + 3;
      while (cyc < base && cyc < acc[0] + 200) stepCycle();
      resetn = 1'b0;
      stepCycle();
      resetn = 1'b1;
      checkOutput("midrst_tx",   32'(evtIf.tx_line),     32'd1);
      checkOutput("midrst_busy", 32'(evtIf.busy),        32'd0);
      checkOutput("midrst_sent", 32'(evtIf.frames_sent), 32'd0);
      lowSeen = 1'b0;
      for (int n = 0; n < 3 * FRAME; n++) begin
         stepCycle();
         if (evtIf.tx_line !== 1'b1) lowSeen = 1'b1;
      end
      checkOutput("midrst_no_frames", 32'(lowSeen), 32'd0);

      $display("[TB] randomized traffic");
      runRandom(1500);
      waitIdle(1000);

      $display("[TB] 256 single events");
      resetn = 1'b0;
      stepCycle();
      resetn = 1'b1;
      for (int i = 0; i < 256; i++) begin
         sendEvent(2'($urandom_range(3)), 3'(i % 8), acc[0], waited);
         waitIdle(200);
         if (i == 254) checkOutput("sent_255", 32'(evtIf.frames_sent), 32'd255);
      end
      checkOutput("sent_wrap", 32'(evtIf.frames_sent), 32'd0);

      checkOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

   function automatic logic [1:0] EVT(input int j);
      return 2'(j);
   endfunction

endmodule
